// File: rtl/rv32i_types.sv
// Shared RV32 M-extension types: op encoding, multiply/divide FSM states and iteration count.
package rv32i_types;

    typedef enum logic [2:0] {
        FnMul    = 3'b000,
        FnMulh   = 3'b001,
        FnMulhsu = 3'b010,
        FnMulhu  = 3'b011,
        FnDiv    = 3'b100,
        FnDivu   = 3'b101,
        FnRem    = 3'b110,
        FnRemu   = 3'b111
    } muldiv_funct3_t;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } muldiv_state_t;

    localparam int unsigned MULDIV_ITERS = 32;

endpackage

// File: rtl/muldiv_iter.sv
// Radix-2 datapath: shift-add multiply or restoring divide, one step per enabled cycle.
// The upper half of acc is the partial product / remainder, the lower half the shift register.
module muldiv_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 step,
    input  logic                 is_div,
    input  logic [WIDTH-1:0]     init_lo,
    input  logic [WIDTH-1:0]     operand,
    output logic [2*WIDTH-1:0]   acc_next
);

    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH-1:0]   rem_diff;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        // Only used when rem_sh >= divisor, so the difference always fits in WIDTH bits.
        rem_diff = rem_sh[WIDTH-1:0] - opnd_q;
        if (is_div) begin
            if (rem_sh >= {1'b0, opnd_q}) begin
                acc_next = {rem_diff, acc_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_next = {mul_sum, acc_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q  <= '0;
            opnd_q <= '0;
        end else if (load) begin
            acc_q  <= {{WIDTH{1'b0}}, init_lo};
            opnd_q <= operand;
        end else if (step) begin
            acc_q  <= acc_next;
        end
    end

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// EX-stage RV32M sequencer: latches an op, runs the 32-step engine (or the divide fast path),
// stalls the front of the pipe while working and presents the result in a one-cycle done slot.
module ex_muldiv_ctrl
    import rv32i_types::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned CNT_W = $clog2(MULDIV_ITERS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MULDIV_ITERS - 1);
    localparam logic [WIDTH-1:0] ONES = '1;
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    muldiv_state_t  state_q;
    muldiv_funct3_t fn, fn_q;
    logic [CNT_W-1:0] count_q;
    logic             neg_q;
    logic [WIDTH-1:0] result_q;

    logic             is_div, neg_a, neg_b, neg_in, fast;
    logic [WIDTH-1:0] a_mag, b_mag, fast_res, qr, final_res;
    logic [2*WIDTH-1:0] acc_next, prod;
    logic             iter_load, iter_step;

    always_comb begin
        fn     = muldiv_funct3_t'(funct3);
        is_div = funct3[2];
        neg_a  = (fn inside {FnMulh, FnMulhsu, FnDiv, FnRem}) & op_a[WIDTH-1];
        neg_b  = (fn inside {FnMulh, FnDiv, FnRem}) & op_b[WIDTH-1];
        a_mag  = neg_a ? -op_a : op_a;
        b_mag  = neg_b ? -op_b : op_b;
        // Remainder follows the dividend's sign; everything else follows the sign product.
        neg_in = (is_div && funct3[1]) ? neg_a : (neg_a ^ neg_b);

        fast     = 1'b0;
        fast_res = '0;
        if (is_div && op_b == '0) begin
            fast     = 1'b1;
            fast_res = funct3[1] ? op_a : ONES;
        end else if ((fn == FnDiv || fn == FnRem) && op_a == MIN_NEG && op_b == ONES) begin
            fast     = 1'b1;
            fast_res = funct3[1] ? '0 : MIN_NEG;
        end
    end

    always_comb begin
        prod = neg_q ? -acc_next : acc_next;
        qr   = fn_q[1] ? acc_next[2*WIDTH-1:WIDTH] : acc_next[WIDTH-1:0];
        if (fn_q[2]) begin
            final_res = neg_q ? -qr : qr;
        end else if (fn_q == FnMul) begin
            final_res = prod[WIDTH-1:0];
        end else begin
            final_res = prod[2*WIDTH-1:WIDTH];
        end
    end

    assign iter_load = (state_q == StIdle) & req & ~flush & ~fast;
    assign iter_step = (state_q == StBusy) & ~flush;

    muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk      (clk),
        .rst      (rst),
        .load     (iter_load),
        .step     (iter_step),
        .is_div   (fn_q[2]),
        .init_lo  (is_div ? a_mag : b_mag),
        .operand  (is_div ? b_mag : a_mag),
        .acc_next (acc_next)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            count_q  <= '0;
            fn_q     <= FnMul;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else if (flush) begin
            state_q <= StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req) begin
                        fn_q    <= fn;
                        neg_q   <= neg_in;
                        count_q <= '0;
                        if (fast) begin
                            result_q <= fast_res;
                            state_q  <= StDone;
                        end else begin
                            state_q  <= StBusy;
                        end
                    end
                end
                StBusy: begin
                    count_q <= count_q + 1'b1;
                    // Final step: load the sign-corrected result so it is valid during DONE.
                    if (count_q == LAST_CNT) begin
                        result_q <= final_res;
                        state_q  <= StDone;
                    end
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign stall  = rst & req & (state_q != StDone);
    assign busy   = (state_q == StBusy);
    assign done   = (state_q == StDone);
    assign result = result_q;

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Directed bench for ex_muldiv_ctrl: latency, stall window, signed/unsigned ops, fast path,
// flush and reset aborts, back-to-back issue.
module tb_ex_muldiv_ctrl;

    logic        clk, rst, req, flush;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b, result;
    logic        stall, busy, done;

    int checks = 0;
    int errors = 0;

    ex_muldiv_ctrl #(
        .WIDTH (32)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .flush  (flush),
        .stall  (stall),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one op at the current negedge (cycle 0) and samples every following negedge until
    // one cycle past done; returns on the negedge where the next op may be issued.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int done_cyc, output int done_cnt,
                          output int stall_hi);
        res = '0; done_cyc = -1; done_cnt = 0; stall_hi = 0;
        funct3 = f; op_a = a; op_b = b; req = 1'b1;
        #1;
        for (int c = 0; c < 40; c++) begin
            if (c > 0) @(negedge clk);
            if (stall) stall_hi++;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = c;
                    res = result;
                end
                req = 1'b0;
            end
            if (done_cyc >= 0 && c > done_cyc) break;
        end
        req = 1'b0;
        if (done_cyc < 0) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; req = 1'b1; flush = 1'b0; funct3 = 3'b000; op_a = 32'd3; op_b = 32'd4;
        @(negedge clk); @(negedge clk);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
        req = 1'b0;
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mul();
        logic [31:0] r; int dc, dn, sh;
        run_op(3'b000, 32'd7, 32'hFFFF_FFFD, r, dc, dn, sh);
        checks++; if (r !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_result got %h want ffffffeb", r); end
        checks++; if (dc !== 33) begin errors++; $display("FAIL mul_latency got %0d want 33", dc); end
        checks++; if (sh !== 33) begin errors++; $display("FAIL mul_stall_cycles got %0d want 33", sh); end
        checks++; if (dn !== 1) begin errors++; $display("FAIL mul_done_count got %0d want 1", dn); end
    endtask

    task automatic test_mul_high();
        logic [31:0] r; int dc, dn, sh;
        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, dc, dn, sh);
        checks++; if (r !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mulhu got %h want fffffffe", r); end
        run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, dc, dn, sh);
        checks++; if (r !== 32'h0000_0000) begin errors++; $display("FAIL mulh got %h want 00000000", r); end
        run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, dc, dn, sh);
        checks++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mulhsu got %h want ffffffff", r); end
        checks++; if (dc !== 33) begin errors++; $display("FAIL mulhsu_latency got %0d want 33", dc); end
    endtask

    task automatic test_div();
        logic [31:0] r; int dc, dn, sh;
        run_op(3'b100, 32'hFFFF_FFF9, 32'd2, r, dc, dn, sh);
        checks++; if (r !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div got %h want fffffffd", r); end
        run_op(3'b110, 32'hFFFF_FFF9, 32'd2, r, dc, dn, sh);
        checks++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rem got %h want ffffffff", r); end
        run_op(3'b101, 32'hFFFF_FFF9, 32'd2, r, dc, dn, sh);
        checks++; if (r !== 32'h7FFF_FFFC) begin errors++; $display("FAIL divu got %h want 7ffffffc", r); end
        checks++; if (dc !== 33) begin errors++; $display("FAIL divu_latency got %0d want 33", dc); end
    endtask

    task automatic test_fast_path();
        logic [31:0] r; int dc, dn, sh;
        run_op(3'b101, 32'd5, 32'd0, r, dc, dn, sh);
        checks++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu_by_zero got %h want ffffffff", r); end
        checks++; if (dc !== 1) begin errors++; $display("FAIL fast_latency got %0d want 1", dc); end
        checks++; if (sh !== 1) begin errors++; $display("FAIL fast_stall_cycles got %0d want 1", sh); end
        checks++; if (dn !== 1) begin errors++; $display("FAIL fast_done_count got %0d want 1", dn); end
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, r, dc, dn, sh);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL rem_overflow got %h want 00000000", r); end
        run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, r, dc, dn, sh);
        checks++; if (r !== 32'h8000_0000) begin errors++; $display("FAIL div_overflow got %h want 80000000", r); end
        checks++; if (dc !== 1) begin errors++; $display("FAIL div_overflow_latency got %0d want 1", dc); end
    endtask

    // Expects the previous test to have left result = 0x80000000.
    task automatic test_flush();
        logic [31:0] r; int dc, dn, sh, ndone;
        funct3 = 3'b000; op_a = 32'd9; op_b = 32'd9; req = 1'b1; flush = 1'b1;
        @(negedge clk);
        req = 1'b0; flush = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL req_with_flush_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL req_with_flush_done got %b want 0", done); end
        @(negedge clk);
        funct3 = 3'b000; op_a = 32'h1234; op_b = 32'h10; req = 1'b1;
        for (int c = 1; c <= 10; c++) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_pre_busy got %b want 1", busy); end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; req = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL flush_done got %b want 0", done); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall got %b want 0", stall); end
        checks++; if (result !== 32'h8000_0000) begin errors++; $display("FAIL flush_result got %h want 80000000", result); end
        ndone = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        checks++; if (ndone !== 0) begin errors++; $display("FAIL flush_no_done got %0d want 0", ndone); end
        run_op(3'b101, 32'd100, 32'd7, r, dc, dn, sh);
        checks++; if (r !== 32'd14) begin errors++; $display("FAIL post_flush_divu got %h want 0000000e", r); end
        checks++; if (dc !== 33) begin errors++; $display("FAIL post_flush_latency got %0d want 33", dc); end
    endtask

    task automatic test_reset_mid();
        funct3 = 3'b011; op_a = 32'hFFFF_0000; op_b = 32'h0001_0000; req = 1'b1;
        for (int c = 1; c <= 5; c++) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_mid_done got %b want 0", done); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_mid_stall got %b want 0", stall); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL rst_mid_result got %h want 0", result); end
        req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [31:0] r; int dc, dn, sh;
        run_op(3'b011, 32'h8000_0000, 32'd4, r, dc, dn, sh);
        checks++; if (r !== 32'd2) begin errors++; $display("FAIL b2b_mulhu got %h want 00000002", r); end
        checks++; if (dn !== 1) begin errors++; $display("FAIL b2b_mulhu_done_count got %0d want 1", dn); end
        run_op(3'b111, 32'd100, 32'd7, r, dc, dn, sh);
        checks++; if (r !== 32'd2) begin errors++; $display("FAIL b2b_remu got %h want 00000002", r); end
        checks++; if (dn !== 1) begin errors++; $display("FAIL b2b_remu_done_count got %0d want 1", dn); end
        checks++; if (dc !== 33) begin errors++; $display("FAIL b2b_remu_latency got %0d want 33", dc); end
    endtask

    initial begin
        rst = 1'b0; req = 1'b0; flush = 1'b0; funct3 = 3'b000; op_a = '0; op_b = '0;
        test_reset();
        test_mul();
        test_mul_high();
        test_div();
        test_fast_path();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
